// File: rtl/ika2151_wrsched_pkg.sv
// Shared types and constants for the IKA2151 host write scheduler.
package ika2151_wrsched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POLL_RD,
    POLL_GAP,
    ADDR_WR,
    ADDR_GAP,
    DATA_WR,
    DATA_GAP
  } wr_state_e;

  localparam int STATUS_BUSY_BIT = 7;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ika2151_wrsched_fifo.sv
// Synchronous 16-bit FIFO holding {addr, data} pairs; extra pointer MSB separates full from empty.
module ika2151_wrsched_fifo #(
  parameter int  FIFO_DEPTH = 16,
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  logic [15:0]   din_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [15:0]   dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  logic [15:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Fullness is judged before any same-cycle pop; a flush swallows a concurrent push.
  assign do_push = push_i && !full_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (do_push)           wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop_i && !empty_o) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/ika2151_wrsched.sv
// Replays queued {addr, data} pairs onto the IKA2151 CPU bus, polling the busy flag before each address write.
module ika2151_wrsched
  import ika2151_wrsched_pkg::*;
#(
  parameter int  FIFO_DEPTH = 16,
  parameter int  PULSE_LEN  = 8,
  parameter int  GAP_LEN    = 4,
  parameter int  POLL_LIMIT = 1024,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1,
  localparam int CW         = $clog2(max2(PULSE_LEN, GAP_LEN)),
  localparam int PW         = $clog2(POLL_LIMIT + 1)
) (
  input  logic          i_EMUCLK,
  input  logic          i_IC_n,
  input  logic          i_PUSH,
  input  logic [7:0]    i_ADDR,
  input  logic [7:0]    i_DATA,
  input  logic          i_FLUSH,
  output logic          o_FULL,
  output logic          o_EMPTY,
  output logic [LW-1:0] o_LEVEL,
  output logic          o_ACTIVE,
  output logic          o_OVF,
  output logic          o_TIMEOUT,
  output logic          o_CS_n,
  output logic          o_RD_n,
  output logic          o_WR_n,
  output logic          o_A0,
  output logic [7:0]    o_D,
  input  logic [7:0]    i_D
);

  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_LEN - 1);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_LIMIT - 1);

  wr_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] poll_q, poll_d;
  logic          busy_q, busy_d;
  logic [7:0]    addr_q, addr_d, data_q, data_d;
  logic          ovf_q, ovf_d, tout_q, tout_d;
  logic          cs_q, cs_d, rd_q, rd_d, wr_q, wr_d, a0_q, a0_d;
  logic [7:0]    dout_q, dout_d;
  logic [15:0]   fifo_head;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic          unused_status;

  // Only the busy bit of the status byte matters here.
  assign unused_status = ^i_D[6:0];

  ika2151_wrsched_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (i_EMUCLK),
    .rst_n_i (i_IC_n),
    .push_i  (i_PUSH),
    .din_i   ({i_ADDR, i_DATA}),
    .pop_i   (fifo_pop),
    .flush_i (i_FLUSH),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (o_LEVEL)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
    poll_d   = poll_q;
    busy_d   = busy_q;
    addr_d   = addr_q;
    data_d   = data_q;
    tout_d   = tout_q;
    ovf_d    = ovf_q | (i_PUSH & fifo_full);
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        fifo_pop         = 1'b1;
        {addr_d, data_d} = fifo_head;
        state_d          = POLL_RD;
        cnt_d            = PULSE_LOAD;
      end
      POLL_RD: if (cnt_q == '0) begin
        busy_d  = i_D[STATUS_BUSY_BIT];
        state_d = POLL_GAP;
        cnt_d   = GAP_LOAD;
      end
      POLL_GAP: if (cnt_q == '0) begin
        cnt_d = PULSE_LOAD;
        if (busy_q && (poll_q < POLL_LAST)) begin
          poll_d  = poll_q + PW'(1);
          state_d = POLL_RD;
        end else begin
          if (busy_q) tout_d = 1'b1;
          state_d = ADDR_WR;
        end
      end
      ADDR_WR:  if (cnt_q == '0) begin state_d = ADDR_GAP; cnt_d = GAP_LOAD;   end
      ADDR_GAP: if (cnt_q == '0) begin state_d = DATA_WR;  cnt_d = PULSE_LOAD; end
      DATA_WR:  if (cnt_q == '0) begin state_d = DATA_GAP; cnt_d = GAP_LOAD;   end
      DATA_GAP: if (cnt_q == '0) begin state_d = IDLE;     poll_d = '0;        end
      default:  state_d = IDLE;
    endcase

    // Bus pins are decoded from the next state so they register alongside it.
    cs_d   = 1'b1;
    rd_d   = 1'b1;
    wr_d   = 1'b1;
    a0_d   = a0_q;
    dout_d = dout_q;
    case (state_d)
      POLL_RD: begin cs_d = 1'b0; rd_d = 1'b0; a0_d = 1'b1; end
      ADDR_WR: begin cs_d = 1'b0; wr_d = 1'b0; a0_d = 1'b0; dout_d = addr_d; end
      DATA_WR: begin cs_d = 1'b0; wr_d = 1'b0; a0_d = 1'b1; dout_d = data_d; end
      default: ;
    endcase
  end

  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      poll_q  <= '0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      tout_q  <= 1'b0;
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      a0_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      poll_q  <= poll_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      tout_q  <= tout_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      a0_q    <= a0_d;
      dout_q  <= dout_d;
    end
  end

  assign o_FULL    = fifo_full;
  assign o_EMPTY   = fifo_empty;
  assign o_ACTIVE  = (state_q != IDLE);
  assign o_OVF     = ovf_q;
  assign o_TIMEOUT = tout_q;
  assign o_CS_n    = cs_q;
  assign o_RD_n    = rd_q;
  assign o_WR_n    = wr_q;
  assign o_A0      = a0_q;
  assign o_D       = dout_q;

endmodule

// File: tb/tb_ika2151_wrsched.sv
// Bench for ika2151_wrsched: queue/timeline reference model, per-cycle compare, replay scoreboard.
module tb_ika2151_wrsched;

  localparam int DEPTH = 16;
  localparam int PL    = 8;
  localparam int GL    = 4;
  localparam int LIM   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push = 1'b0, flush = 1'b0;
  logic [7:0] addr = '0, data = '0, din = '0;
  logic       cs_n, rd_n, wr_n, a0, active, full, empty, ovf, tout;
  logic [7:0] dout;
  logic [4:0] level;

  ika2151_wrsched #(.FIFO_DEPTH(DEPTH), .PULSE_LEN(PL), .GAP_LEN(GL), .POLL_LIMIT(LIM)) dut (
    .i_EMUCLK(clk), .i_IC_n(rst_n), .i_PUSH(push), .i_ADDR(addr), .i_DATA(data),
    .i_FLUSH(flush), .o_FULL(full), .o_EMPTY(empty), .o_LEVEL(level), .o_ACTIVE(active),
    .o_OVF(ovf), .o_TIMEOUT(tout), .o_CS_n(cs_n), .o_RD_n(rd_n), .o_WR_n(wr_n),
    .o_A0(a0), .o_D(dout), .i_D(din)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct { logic [7:0] a; logic [7:0] d; int b; } entry_t;
  typedef struct {
    bit cs, rd, wr, a0, chk_a0, chk_d;
    logic [7:0] d;
    int pidx;
    bit last_rd, tset;
    int ph;  // 0 idle, 1 polling, 2 addr write, 3 addr gap, 4 data write, 5 data gap
  } cyc_t;

  entry_t      mq[$];
  cyc_t        wq[$];
  cyc_t        cur;
  logic [15:0] exp_q[$];
  bit          m_active, m_ovf, m_tout, fullb, chk_en = 1'b0;
  int          cur_b, next_b = 0;
  int          n_checks = 0, n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic cyc_t mk(bit cs, bit rd, bit wr, bit a0v, bit ca0, bit cd,
                              logic [7:0] dv, int pidx, bit last, bit ts, int ph);
    cyc_t c;
    c.cs = cs; c.rd = rd; c.wr = wr; c.a0 = a0v; c.chk_a0 = ca0; c.chk_d = cd;
    c.d = dv; c.pidx = pidx; c.last_rd = last; c.tset = ts; c.ph = ph;
    return c;
  endfunction

  // Whole bus timeline of one entry, given how many polls the core reports busy.
  task automatic build(input entry_t e);
    int n;
    n = (e.b >= LIM) ? LIM : e.b + 1;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < PL; i++) wq.push_back(mk(0, 0, 1, 1, 1, 0, 8'h00, k, i == PL-1, 0, 1));
      for (int i = 0; i < GL; i++) wq.push_back(mk(1, 1, 1, 1, 0, 0, 8'h00, k, 0, 0, 1));
    end
    for (int i = 0; i < PL; i++) wq.push_back(mk(0, 1, 0, 0, 1, 1, e.a, 0, 0, (i == 0) && (e.b >= LIM), 2));
    for (int i = 0; i < GL; i++) wq.push_back(mk(1, 1, 1, 0, 0, 1, e.a, 0, 0, 0, 3));
    for (int i = 0; i < PL; i++) wq.push_back(mk(0, 1, 0, 1, 1, 1, e.d, 0, 0, 0, 4));
    for (int i = 0; i < GL; i++) wq.push_back(mk(1, 1, 1, 0, 0, 0, 8'h00, 0, 0, 0, 5));
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete(); wq.delete(); exp_q.delete();
      cur = mk(1, 1, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
      m_active = 0; m_ovf = 0; m_tout = 0; cur_b = 0;
    end else begin
      fullb = (mq.size() == DEPTH);
      if (!m_active && mq.size() > 0) begin
        entry_t e;
        e = mq.pop_front();
        build(e);
        exp_q.push_back({e.a, e.d});
        cur_b = e.b;
      end
      if (flush) mq.delete();
      else if (push && !fullb) mq.push_back('{addr, data, next_b});
      if (push && fullb) m_ovf = 1;
      if (wq.size() > 0) begin
        cur = wq.pop_front();
        m_active = 1;
        if (cur.tset) m_tout = 1;
      end else begin
        cur = mk(1, 1, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        m_active = 0;
      end
    end
  end

  // Status responder: the busy bit is only meaningful on the last cycle of a read strobe.
  always @(negedge clk) begin
    if (m_active && cur.last_rd) din = {(cur.pidx < cur_b), 7'($urandom)};
    else                         din = 8'($urandom);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("cs_n", cs_n, cur.cs);
      check("rd_n", rd_n, cur.rd);
      check("wr_n", wr_n, cur.wr);
      check("active", active, m_active);
      check("level", level, mq.size());
      check("full", full, mq.size() == DEPTH);
      check("empty", empty, mq.size() == 0);
      check("ovf", ovf, m_ovf);
      check("timeout", tout, m_tout);
      if (cur.chk_a0) check("a0", a0, cur.a0);
      if (cur.chk_d)  check("d", dout, cur.d);
    end
  end

  // ---------------- bus monitor / replay scoreboard ----------------
  int         rd_falls = 0, wr_falls = 0, act_cyc = 0;
  logic       prev_rd = 1'b1, prev_wr = 1'b1;
  logic [7:0] got_addr = '0, last_a = '0, last_d = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rd = 1'b1; prev_wr = 1'b1;
    end else begin
      if (prev_rd && !rd_n) rd_falls++;
      if (prev_wr && !wr_n) begin
        wr_falls++;
        if (!a0) got_addr = dout;
        else begin
          last_a = got_addr; last_d = dout;
          if (exp_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL replay_extra actual=%0h required=none t=%0t", {got_addr, dout}, $time);
          end else check("replay", {got_addr, dout}, exp_q.pop_front());
        end
      end
      if (active) act_cyc++;
      prev_rd = rd_n; prev_wr = wr_n;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_push(input logic [7:0] a, input logic [7:0] d, input int b);
    push = 1'b1; addr = a; data = d; next_b = b;
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((active || !empty) && n < budget) begin @(negedge clk); n++; end
    if (active || !empty) begin
      n_checks++; n_err++;
      $display("FAIL wait_idle actual=busy required=idle budget=%0d", budget);
    end
    @(negedge clk);
  endtask

  task automatic wait_phase(input int ph, input int budget);
    int n = 0;
    while (cur.ph != ph && n < budget) begin @(negedge clk); n++; end
    if (cur.ph != ph) begin
      n_checks++; n_err++;
      $display("FAIL wait_phase actual=%0d required=%0d", cur.ph, ph);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  int r0, w0, c0, lat;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 1); check("rst_rd_n", rd_n, 1); check("rst_wr_n", wr_n, 1);
    check("rst_a0", a0, 0); check("rst_d", dout, 0); check("rst_empty", empty, 1);
    check("rst_full", full, 0); check("rst_level", level, 0); check("rst_active", active, 0);
    check("rst_ovf", ovf, 0); check("rst_timeout", tout, 0);
    rst_n = 1'b1; chk_en = 1'b1;
    @(negedge clk);

    // single write, core not busy
    r0 = rd_falls; w0 = wr_falls; c0 = act_cyc;
    do_push(8'h20, 8'hC7, 0);
    lat = 1;
    while (cs_n && lat < 20) begin @(negedge clk); lat++; end
    check("push_to_cs_latency", lat, 2);
    wait_idle(200);
    check("t1_reads", rd_falls - r0, 1);
    check("t1_writes", wr_falls - w0, 2);
    check("t1_active_cycles", act_cyc - c0, 36);
    check("t1_addr", last_a, 8'h20);
    check("t1_data", last_d, 8'hC7);

    // busy for three polls
    r0 = rd_falls;
    do_push(8'h28, 8'h3A, 3);
    wait_idle(400);
    check("t2_reads", rd_falls - r0, 4);
    check("t2_timeout", tout, 0);
    check("t2_addr", last_a, 8'h28);

    // busy forever: gives up after POLL_LIMIT reads
    r0 = rd_falls; w0 = wr_falls;
    do_push(8'h30, 8'h55, 9);
    wait_idle(400);
    check("t3_reads", rd_falls - r0, 4);
    check("t3_writes", wr_falls - w0, 2);
    check("t3_timeout", tout, 1);

    // fill past capacity while the core stays busy
    w0 = wr_falls;
    for (int i = 0; i < 17; i++) do_push(8'(i), 8'(8'hA0 + i), 20);
    check("t4_level", level, 16);
    check("t4_full", full, 1);
    check("t4_no_ovf", ovf, 0);
    do_push(8'hFF, 8'hFF, 0);
    check("t4_ovf", ovf, 1);
    wait_idle(2500);
    check("t4_writes", wr_falls - w0, 34);

    // flush during the first entry's address write
    r0 = rd_falls; w0 = wr_falls;
    for (int i = 0; i < 6; i++) do_push(8'(8'h40 + i), 8'(8'h60 + i), 0);
    wait_phase(2, 100);
    flush = 1'b1; push = 1'b1; addr = 8'h77; data = 8'h77; next_b = 0;
    @(negedge clk);
    flush = 1'b0; push = 1'b0;
    check("t5_level", level, 0);
    wait_idle(300);
    repeat (20) @(negedge clk);
    check("t5_reads", rd_falls - r0, 1);
    check("t5_writes", wr_falls - w0, 2);
    check("t5_last_addr", last_a, 8'h40);

    // asynchronous reset in the middle of a data write
    for (int i = 0; i < 3; i++) do_push(8'(8'h50 + i), 8'(8'h70 + i), 0);
    wait_phase(4, 100);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_wr_n", wr_n, 1); check("t6_cs_n", cs_n, 1);
    check("t6_empty", empty, 1); check("t6_active", active, 0);
    check("t6_ovf_cleared", ovf, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; chk_en = 1'b1;
    r0 = rd_falls; w0 = wr_falls;
    repeat (20) @(negedge clk);
    check("t6_idle_reads", rd_falls - r0, 0);
    check("t6_idle_writes", wr_falls - w0, 0);
    do_push(8'h08, 8'h01, 1);
    wait_idle(300);
    check("t6_recover_addr", last_a, 8'h08);

    // randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      push = ($urandom_range(0, 2) != 0);
      addr = 8'($urandom); data = 8'($urandom);
      next_b = $urandom_range(0, 5);
      flush = ($urandom_range(0, 60) == 0);
      @(negedge clk);
    end
    push = 1'b0; flush = 1'b0;
    wait_idle(4000);
    repeat (5) @(negedge clk);
    check("replay_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
